// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the instruction-fetch path (if_*)
// and the load/store path (d_*). One access is in flight at a time; a
// granted access is held for MEM_LAT cycles and completes with a
// one-cycle rvalid pulse to its owner. Ties are broken round-robin.
//
// Ports:
//   clk, reset          clock (rising edge), async active-low reset
//   if_req/if_addr      fetch request (always a read), held until if_gnt
//   if_gnt/if_rvalid    fetch accepted / fetch data valid (if_rdata)
//   d_req/d_we/d_addr/d_wdata  data request, held until d_gnt
//   d_gnt/d_rvalid      data accepted / read data valid or write done (d_rdata)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port
//   busy                access in flight
//
// state | meaning
// IDLE  | no access in flight; arbitrate and issue in the same cycle
// WAIT  | counting memory latency; rvalid on the last count
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Requester encoding for owner/last: 0 = fetch, 1 = data.
    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_D  = 1'b1;

    state_t             state, state_nxt;
    logic               owner, last;
    logic               owner_we;
    logic [CNT_W-1:0]   cnt;
    logic               sel_d;
    logic               issue;
    logic               done;

    // Data wins when it is the only requester, or on a tie when fetch went last.
    assign sel_d = d_req && (!if_req || (last == SEL_IF));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            owner    <= SEL_IF;
            last     <= SEL_D;
            owner_we <= 1'b0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                owner    <= sel_d;
                last     <= sel_d;
                owner_we <= sel_d && d_we;
                cnt      <= CNT_W'(MEM_LAT);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done      = 1'b0;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        busy      = 1'b0;

        // Everything is forced low while reset is held, combinational paths included.
        if (reset) begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        issue     = 1'b1;
                        state_nxt = WAIT;
                        mem_en    = 1'b1;
                        if (sel_d) begin
                            d_gnt     = 1'b1;
                            mem_we    = d_we;
                            mem_addr  = d_addr;
                            mem_wdata = d_wdata;
                        end else begin
                            if_gnt   = 1'b1;
                            mem_addr = if_addr;
                        end
                    end
                end
                WAIT: begin
                    busy = 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase

            if (done) begin
                if (owner == SEL_D) begin
                    d_rvalid = 1'b1;
                    d_rdata  = owner_we ? '0 : mem_rdata;
                end else begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port unified instruction/data memory of the multicycle CPU between two requesters: the instruction-fetch path and the load/store data path. It accepts requests with a req/gnt handshake and arbitrates ties round-robin. It issues one memory access at a time, counts a fixed memory latency, and returns read data with a one-cycle valid pulse to the requester that owns the access. The control FSM stalls its FETCH and memory states until the matching rvalid pulse.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range >= 1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  one-cycle pulse: fetch data valid
if_rdata  out  DATA_W  fetch data; mem_rdata when if_rvalid=1, else 0
d_req  in  1  data request; held until d_gnt
d_we  in  1  1=write, 0=read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle pulse: read data valid or write complete
d_rdata  out  DATA_W  mem_rdata when d_rvalid=1 on a read; 0 otherwise (including write acks)
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  access in flight (state != IDLE)

Behaviour:
- States: IDLE, WAIT. Registers: state, owner (IF/D), last (IF/D), cnt (width clog2(MEM_LAT+1)).
- While reset=0: state=IDLE, cnt=0, owner=IF, last=D. All outputs are forced to 0, including the combinational gnt/mem signals.
- IDLE, no req: all outputs 0.
- IDLE with any req (cycle T):
  - Winner: the only requester, or on a tie the one that is not `last` (round-robin).
  - The winner's gnt=1 combinationally in cycle T. mem_en=1 in cycle T, with mem_addr, mem_we, mem_wdata muxed from the winner.
  - Fetch is always a read (mem_we=0, mem_wdata=0).
  - At the edge: owner<=winner, last<=winner, cnt<=MEM_LAT, state<=WAIT.
- WAIT:
  - No gnt and no mem_en. Requests are held off and stay pending.
  - cnt decrements each cycle.
  - In the cycle where cnt==1 (cycle T+MEM_LAT): the owner's rvalid=1, rdata=mem_rdata (0 for writes), state<=IDLE.
- Throughput: one access per MEM_LAT+1 cycles. Earliest next grant is T+MEM_LAT+1.
- Only one of if_gnt/d_gnt and one of if_rvalid/d_rvalid is ever high. The gnt and rvalid of one access never share a cycle.
- A req dropped before gnt is legal and ignored. Inputs are sampled only in the gnt cycle; later changes do not affect the access in flight.
- Reset mid-WAIT: the access is abandoned and no rvalid is issued. The next request after release wins per the reset value of `last` (IF wins a tie).
- MEM_LAT=1: gnt at T, rvalid at T+1.

Test Plan:
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x40 at cycle 0; memory returns 0xDEADBEEF in cycle 2 -> if_gnt=1, mem_en=1, mem_addr=0x40, mem_we=0 in cycle 0; busy cycles 1–2; if_rvalid=1, if_rdata=0xDEADBEEF in cycle 2 only.
- Data write: d_req=1, d_we=1, d_addr=0x100, d_wdata=0x1234 at cycle 0 -> mem_en=1, mem_we=1, mem_addr=0x100, mem_wdata=0x1234 in cycle 0; d_rvalid=1, d_rdata=0 in cycle 2.
- Tie after reset: if_req and d_req both held from cycle 0 -> if_gnt at cycle 0, d_gnt at cycle 3, if_gnt at cycle 6; strict alternation continues while both stay high.
- Request during WAIT: if_req at cycle 0, d_req raised at cycle 1 -> d_gnt is not asserted until cycle 3; d_rvalid at cycle 5.
- Reset mid-access: if_req at cycle 0; reset=0 in cycle 1 for one cycle -> no if_rvalid; all outputs 0 during reset; busy=0 afterwards; a held if_req is granted in the first cycle after release.
- MEM_LAT=1 read: d_req=1, d_we=0 at cycle 0 -> d_gnt cycle 0, d_rvalid with mem_rdata in cycle 1, next grant possible in cycle 2.
